// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA enqueue bytes in a FIFO,
// and a baud-timed serializer drains them onto uart_tx.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_en,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_hit,
    output logic        uart_tx,
    output logic        tx_idle
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = 3;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(7);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              bus_en_q;
    logic              ctrl_en;
    logic              ovf;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_nxt;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_nxt;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_nxt;
    logic              tx_nxt;

    logic [1:0]        reg_sel_c;
    logic              acc_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic              busy_c;
    logic              bit_end_c;
    logic              pop_c;
    logic              push_c;
    logic              ovf_set_c;
    logic              ovf_clr_c;
    logic [31:0]       rd_val_c;
    logic              unused_c;

    // Address decode; only the first cycle of a held strobe counts as an access.
    assign bus_hit   = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel_c = bus_addr[3:2];
    assign acc_c     = bus_en & bus_hit & ~bus_en_q;
    assign wr_acc_c  = acc_c & bus_we;
    assign rd_acc_c  = acc_c & ~bus_we;

    assign fifo_full_c  = (count == FULL_CNT);
    assign fifo_empty_c = (count == '0);
    assign busy_c       = (state != ST_IDLE);
    assign bit_end_c    = (baud == BAUD_LAST);

    // A full FIFO still accepts a byte when the serializer frees a slot that cycle.
    assign push_c    = wr_acc_c && (reg_sel_c == REG_TXDATA) && (!fifo_full_c || pop_c);
    assign ovf_set_c = wr_acc_c && (reg_sel_c == REG_TXDATA) && fifo_full_c && !pop_c;
    assign ovf_clr_c = wr_acc_c && (reg_sel_c == REG_STATUS) && bus_wdata[3];

    assign unused_c = ^{bus_addr[1:0], bus_wdata[31:8]};

    // Register read mux.
    always_comb begin
        rd_val_c = '0;
        case (reg_sel_c)
            REG_STATUS: rd_val_c = {24'b0, 4'(count), ovf, busy_c, fifo_empty_c, fifo_full_c};
            REG_CTRL:   rd_val_c = {31'b0, ctrl_en};
            default:    rd_val_c = '0;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (push_c && !pop_c) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Bus-side state: strobe edge detect, FIFO pointers, control and status bits, read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_en_q  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            ctrl_en   <= 1'b1;
            bus_rdata <= '0;
        end else begin
            bus_en_q <= bus_en;
            count    <= count_nxt;
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (ovf_set_c) begin
                ovf <= 1'b1;
            end else if (ovf_clr_c) begin
                ovf <= 1'b0;
            end
            if (wr_acc_c && (reg_sel_c == REG_CTRL)) begin
                ctrl_en <= bus_wdata[0];
            end
            if (rd_acc_c) begin
                bus_rdata <= rd_val_c;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= bus_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Serializer next-state; each state or data bit lasts one full baud period.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bit_nxt   = bit_idx;
        shift_nxt = shift_reg;
        pop_c     = 1'b0;
        tx_nxt    = 1'b1;

        case (state)
            ST_IDLE: begin
                if (ctrl_en && !fifo_empty_c) begin
                    pop_c     = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    baud_nxt  = '0;
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_nxt = bit_idx + BIT_W'(1);
                    end
                end else begin
                    baud_nxt = baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    baud_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    baud_nxt = baud + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Line level is derived from the upcoming state so the register lines up with it.
        case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
            tx_idle   <= 1'b1;
        end else begin
            baud      <= baud_nxt;
            bit_idx   <= bit_nxt;
            shift_reg <= shift_nxt;
            uart_tx   <= tx_nxt;
            tx_idle   <= (count_nxt == '0) && (state_nxt == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a queue/countdown reference model predicts load data
// and transmitted frames; independent monitors decode the serial line and check the bus.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bus_en = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic        uart_tx;
    logic        tx_idle;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [7:0]  data;
        int unsigned start;
    } frame_t;

    frame_t      exp_tx[$];
    logic [31:0] exp_rd[$];

    // Reference model state: queued bytes, sticky flags, cycles left in the current frame.
    logic [7:0]  m_q[$];
    logic        m_ovf  = 1'b0;
    logic        m_ctrl = 1'b1;
    logic        m_enq  = 1'b0;
    int unsigned m_left = 0;
    int unsigned mcyc   = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_en   (bus_en),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_hit  (bus_hit),
        .uart_tx  (uart_tx),
        .tx_idle  (tx_idle)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_hit(input logic [31:0] a);
        logic [31:0] b;
        b = BASE;
        return a[31:4] == b[31:4];
    endfunction

    // Reference model, evaluated on the same edges as the DUT with pre-edge inputs.
    initial begin : model
        logic        acc;
        logic        pop;
        logic [31:0] rv;
        frame_t      f;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                exp_tx.delete();
                exp_rd.delete();
                m_ovf  = 1'b0;
                m_ctrl = 1'b1;
                m_enq  = 1'b0;
                m_left = 0;
            end else begin
                mcyc++;
                acc   = bus_en && is_hit(bus_addr) && !m_enq;
                m_enq = bus_en;
                if (acc && !bus_we) begin
                    case (bus_addr[3:2])
                        2'd1: rv = {24'b0, 4'(m_q.size()), m_ovf, (m_left != 0),
                                    (m_q.size() == 0), (m_q.size() == DEPTH)};
                        2'd2: rv = {31'b0, m_ctrl};
                        default: rv = 32'd0;
                    endcase
                    exp_rd.push_back(rv);
                end
                pop = (m_left == 0) && m_ctrl && (m_q.size() != 0);
                if (pop) begin
                    f.data  = m_q.pop_front();
                    f.start = mcyc;
                    exp_tx.push_back(f);
                    m_left = FRAME;
                end else if (m_left != 0) begin
                    m_left--;
                end
                if (acc && bus_we) begin
                    case (bus_addr[3:2])
                        2'd0: begin
                            if (m_q.size() < DEPTH) m_q.push_back(bus_wdata[7:0]);
                            else m_ovf = 1'b1;
                        end
                        2'd1: if (bus_wdata[3]) m_ovf = 1'b0;
                        2'd2: m_ctrl = bus_wdata[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Bus monitor: pops predicted load data when a load completes, otherwise data must hold.
    initial begin : bus_mon
        logic [31:0] rd_hold;
        rd_hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_hold = '0;
            end else begin
                if (exp_rd.size() != 0) begin
                    rd_hold = exp_rd.pop_front();
                    check("load_data", bus_rdata, rd_hold);
                end else begin
                    check("rdata_hold", bus_rdata, rd_hold);
                end
                check("tx_idle", 32'(tx_idle), 32'((m_q.size() == 0) && (m_left == 0)));
                if (m_left == 0) check("line_idle_high", 32'(uart_tx), 32'd1);
            end
        end
    end

    // Serial receiver: samples mid-bit and compares each frame with the predicted one.
    initial begin : rx_mon
        logic        prev;
        logic        ab;
        logic        st_bit;
        logic        sp_bit;
        logic [7:0]  d;
        int unsigned st;
        frame_t      f;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && !uart_tx) begin
                st = mcyc;
                ab = 1'b0;
                d  = '0;
                for (int k = 0; k < CPB / 2; k++) begin @(negedge clk); if (rst) ab = 1'b1; end
                st_bit = uart_tx;
                for (int b = 0; b < 8; b++) begin
                    for (int k = 0; k < CPB; k++) begin @(negedge clk); if (rst) ab = 1'b1; end
                    d[b] = uart_tx;
                end
                for (int k = 0; k < CPB; k++) begin @(negedge clk); if (rst) ab = 1'b1; end
                sp_bit = uart_tx;
                if (!ab) begin
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected_frame: got 0x%02h expected no frame", d);
                    end else begin
                        f = exp_tx.pop_front();
                        check("tx_data", 32'(d), 32'(f.data));
                        check("tx_start_cycle", st, f.start);
                        check("tx_start_bit", 32'(st_bit), 32'd0);
                        check("tx_stop_bit", 32'(sp_bit), 32'd1);
                    end
                end
                prev = ab ? 1'b1 : uart_tx;
            end else begin
                prev = uart_tx;
            end
        end
    end

    // One bus access starting at a negedge; strobe held 'hold' cycles, then one idle cycle.
    task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                              input int unsigned hold);
        bus_en    = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = data;
        #1;
        check("bus_hit", 32'(bus_hit), 32'(is_hit(addr)));
        repeat (hold) @(negedge clk);
        bus_en = 1'b0;
        bus_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_left(input int unsigned val);
        int unsigned n;
        n = 0;
        while (m_left != val && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_left != val) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_phase: timed out with left=%0d required=%0d", m_left, val);
        end
    endtask

    task automatic wait_drain(input string name);
        int unsigned n;
        n = 0;
        while ((m_q.size() != 0 || m_left != 0 || exp_tx.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timed out with %0d bytes queued, %0d frames pending",
                     name, m_q.size(), exp_tx.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        logic [31:0] a;
        int unsigned op;

        // Reset values.
        #1 rst = 1'b1;
        #1;
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_bus_hit", 32'(bus_hit), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single byte, then status.
        bus_access(1'b1, BASE, 32'h55, 2);
        bus_access(1'b0, BASE + 32'h4, 32'h0, 2);
        wait_drain("drain_single");
        bus_access(1'b0, BASE + 32'h4, 32'h0, 3);

        // Burst overruns the FIFO, then ovf is cleared through STATUS.
        for (int i = 0; i < 6; i++) bus_access(1'b1, BASE, 32'hA1 + 32'(i), 2);
        bus_access(1'b0, BASE + 32'h4, 32'h0, 2);
        bus_access(1'b1, BASE + 32'h4, 32'h8, 2);
        bus_access(1'b0, BASE + 32'h4, 32'h0, 2);
        wait_drain("drain_burst");

        // Disable mid-frame: the frame completes, the queued byte waits for re-enable.
        bus_access(1'b1, BASE, 32'h3C, 2);
        bus_access(1'b1, BASE, 32'hC3, 2);
        wait_left(23);
        bus_access(1'b1, BASE + 32'h8, 32'h0, 2);
        wait_left(0);
        repeat (10) @(negedge clk);
        bus_access(1'b0, BASE + 32'h4, 32'h0, 2);
        bus_access(1'b1, BASE + 32'h8, 32'h1, 2);
        wait_drain("drain_ctrl");

        // Register reads including an unmapped slot and a miss.
        bus_access(1'b0, BASE + 32'h8, 32'h0, 2);
        bus_access(1'b0, BASE + 32'hC, 32'h0, 2);
        bus_access(1'b0, 32'h0000_2000, 32'h0, 2);
        bus_access(1'b1, 32'h0000_2000, 32'h77, 2);
        bus_access(1'b0, BASE, 32'h0, 2);

        // Reset during data bit 5 with two bytes queued.
        bus_access(1'b1, BASE, 32'h0F, 2);
        bus_access(1'b1, BASE, 32'hAA, 2);
        bus_access(1'b1, BASE, 32'hBB, 2);
        wait_left(14);
        #2;
        check("pre_rst_line", 32'(uart_tx), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async_tx", 32'(uart_tx), 32'd1);
        check("rst_async_idle", 32'(tx_idle), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        bus_access(1'b0, BASE + 32'h4, 32'h0, 2);
        repeat (100) @(negedge clk);

        // Full FIFO: a store landing on the pop cycle is accepted.
        bus_access(1'b1, BASE, 32'h11, 2);
        for (int i = 0; i < 4; i++) bus_access(1'b1, BASE, 32'h22 + 32'(i * 17), 2);
        @(negedge clk);
        wait_left(0);
        bus_access(1'b1, BASE, 32'h77, 2);
        bus_access(1'b0, BASE + 32'h4, 32'h0, 2);
        wait_drain("drain_full");

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: bus_access(1'b1, BASE | 32'($urandom_range(0, 3)), 32'($urandom),
                                       $urandom_range(2, 3));
                4: bus_access(1'b0, BASE + 32'h4, 32'h0, $urandom_range(2, 3));
                5: bus_access(1'b1, BASE + 32'h4, 32'($urandom), $urandom_range(2, 3));
                6: bus_access(1'b1, BASE + 32'h8,
                              {31'($urandom), 1'($urandom_range(0, 3) != 0)}, $urandom_range(2, 3));
                7: bus_access(1'b0, BASE | 32'($urandom_range(0, 15)), 32'h0, $urandom_range(2, 3));
                8: begin
                    a = $urandom;
                    if (is_hit(a)) a = a ^ 32'h0010_0000;
                    bus_access(1'($urandom_range(0, 1)), a, 32'($urandom), $urandom_range(2, 3));
                end
                default: repeat ($urandom_range(1, 30)) @(negedge clk);
            endcase
        end
        bus_access(1'b1, BASE + 32'h8, 32'h1, 2);
        wait_drain("drain_random");
        bus_access(1'b0, BASE + 32'h4, 32'h0, 2);
        @(negedge clk);

        check("frames_outstanding", 32'(exp_tx.size()), 32'd0);
        check("loads_outstanding", 32'(exp_rd.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
